// File: rtl/call_stack_unit.sv
// Parametrised return-address / operand LIFO built on a circular buffer.
// It supports optional wrap-on-full, replacing the top entry, flush, and sticky error flags.
module call_stack_unit #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8,
   parameter bit WRAP  = 1'b0
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic                       i_clear_err,
   input  logic [WIDTH-1:0]           i_data_in,
   output logic [WIDTH-1:0]           o_top,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_overflow,
   output logic                       o_underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wp;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             r_underflow;

   logic [PW-1:0]    w_wpInc;
   logic [PW-1:0]    w_wpDec;
   logic             w_empty;
   logic             w_full;
   logic             w_pushOnly;
   logic             w_popOnly;
   logic             w_replace;
   logic             w_advance;
   logic             w_retreat;
   logic             w_memWe;
   logic [PW-1:0]    w_memAddr;
   logic             w_ovfEvent;
   logic             w_unfEvent;

   // The pointers wrap explicitly, so DEPTH does not have to be a power of two.
   assign w_wpInc = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
   assign w_wpDec = (r_wp == '0) ? PW'(DEPTH - 1) : r_wp - PW'(1);

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   assign w_pushOnly = !i_flush && i_push && !i_pop;
   assign w_popOnly  = !i_flush && !i_pop ? 1'b0 : (!i_flush && !i_push);
   assign w_replace  = !i_flush && i_push && i_pop && !w_empty;

   // Push+pop on an empty stack degenerates to a plain push.
   assign w_advance  = (w_pushOnly && (!w_full || WRAP))
                    || (!i_flush && i_push && i_pop && w_empty);
   assign w_retreat  = w_popOnly && !w_empty;

   assign w_memWe    = w_advance || w_replace;
   assign w_memAddr  = w_replace ? w_wpDec : r_wp;

   assign w_ovfEvent = w_pushOnly && w_full;
   assign w_unfEvent = w_popOnly && w_empty;

   always_ff @(posedge i_clk) begin
      if (w_memWe) begin
         r_mem[w_memAddr] <= i_data_in;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wp        <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (i_flush) begin
            r_count <= '0;
         end else if (w_advance) begin
            r_wp <= w_wpInc;
            if (!w_full) begin
               r_count <= r_count + CW'(1);
            end
         end else if (w_retreat) begin
            r_wp    <= w_wpDec;
            r_count <= r_count - CW'(1);
         end
         // A new error event in the same cycle as clear_err keeps the flag set.
         r_overflow  <= w_ovfEvent || (r_overflow && !i_clear_err);
         r_underflow <= w_unfEvent || (r_underflow && !i_clear_err);
      end
   end

   assign o_top       = w_empty ? '0 : r_mem[w_wpDec];
   assign o_count     = r_count;
   assign o_empty     = w_empty;
   assign o_full      = w_full;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: tb/tb_call_stack_unit.sv
// Directed bench for call_stack_unit at DEPTH=4, WIDTH=12.
// It runs two instances from one stimulus stream: dut0 rejects pushes when full, and dut1 wraps.
module tb_call_stack_unit;

   localparam int WIDTH = 12;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic             push;
   logic             pop;
   logic             flush;
   logic             clearErr;
   logic [WIDTH-1:0] dataIn;

   logic [WIDTH-1:0] top0, top1;
   logic [CW-1:0]    count0, count1;
   logic             empty0, empty1, full0, full1;
   logic             ovf0, ovf1, unf0, unf1;

   int testCount = 0;
   int failCount = 0;

   call_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1'b0)) dut0 (
      .i_clk(clk), .i_reset(reset), .i_push(push), .i_pop(pop),
      .i_flush(flush), .i_clear_err(clearErr), .i_data_in(dataIn),
      .o_top(top0), .o_count(count0), .o_empty(empty0), .o_full(full0),
      .o_overflow(ovf0), .o_underflow(unf0)
   );

   call_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1'b1)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_push(push), .i_pop(pop),
      .i_flush(flush), .i_clear_err(clearErr), .i_data_in(dataIn),
      .o_top(top1), .o_count(count1), .o_empty(empty1), .o_full(full1),
      .o_overflow(ovf1), .o_underflow(unf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of controls, clock it in, and leave the outputs settled 1ns past the edge.
   task automatic applyStimulus(input logic p, input logic q, input logic f,
                                input logic c, input logic [WIDTH-1:0] d);
      push = p; pop = q; flush = f; clearErr = c; dataIn = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clearErr = 1'b0; dataIn = '0;
   endtask

   initial begin
      logic [WIDTH-1:0] exp0 [4];
      logic [WIDTH-1:0] exp1 [4];
      exp0 = '{12'h004, 12'h003, 12'h002, 12'h001};
      exp1 = '{12'h006, 12'h005, 12'h004, 12'h003};

      reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clearErr = 1'b0; dataIn = '0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checkOutput("rst_count", 32'(count0), 0);
      checkOutput("rst_empty", 32'(empty0), 1);
      checkOutput("rst_full",  32'(full0), 0);
      checkOutput("rst_top",   32'(top0), 0);
      checkOutput("rst_flags", {30'd0, ovf0, unf0}, 0);

      // Basic push/pop
      applyStimulus(1, 0, 0, 0, 12'h011);
      checkOutput("push1_top", 32'(top0), 32'h011);
      applyStimulus(1, 0, 0, 0, 12'h022);
      applyStimulus(1, 0, 0, 0, 12'h033);
      checkOutput("push3_count", 32'(count0), 3);
      checkOutput("push3_top",   32'(top0), 32'h033);
      applyStimulus(0, 1, 0, 0, '0);
      checkOutput("pop1_top", 32'(top0), 32'h022);
      applyStimulus(0, 1, 0, 0, '0);
      checkOutput("pop2_top",   32'(top0), 32'h011);
      checkOutput("pop2_count", 32'(count0), 1);
      checkOutput("pop2_flags", {30'd0, ovf0, unf0}, 0);
      applyStimulus(0, 1, 0, 0, '0);
      checkOutput("drain_empty", 32'(empty0), 1);

      // Overflow: reject (dut0) versus wrap (dut1)
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1, 0, 0, 0, WIDTH'(i));
         if (i == 4) begin
            checkOutput("fill_full0", 32'(full0), 1);
            checkOutput("fill_ovf0",  32'(ovf0), 0);
         end
         if (i == 5) begin
            checkOutput("ovf5_top0", 32'(top0), 32'h004);
            checkOutput("ovf5_ovf0", 32'(ovf0), 1);
            checkOutput("ovf5_top1", 32'(top1), 32'h005);
         end
      end
      checkOutput("ovf_count0", 32'(count0), 4);
      checkOutput("ovf_count1", 32'(count1), 4);
      checkOutput("ovf_full1",  32'(full1), 1);
      checkOutput("ovf_flag1",  32'(ovf1), 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("drain%0d_top0", i), 32'(top0), 32'(exp0[i]));
         checkOutput($sformatf("drain%0d_top1", i), 32'(top1), 32'(exp1[i]));
         applyStimulus(0, 1, 0, 0, '0);
      end
      checkOutput("drained_empty0", 32'(empty0), 1);
      checkOutput("drained_top0",   32'(top0), 0);
      checkOutput("drained_top1",   32'(top1), 0);
      checkOutput("ovf_sticky0",    32'(ovf0), 1);
      checkOutput("no_unf0",        32'(unf0), 0);

      // Sticky flag handling
      applyStimulus(0, 0, 0, 1, '0);
      checkOutput("clr_ovf0", 32'(ovf0), 0);
      applyStimulus(0, 1, 0, 0, '0);
      checkOutput("unf_set",   32'(unf0), 1);
      checkOutput("unf_count", 32'(count0), 0);
      applyStimulus(0, 0, 0, 1, '0);
      checkOutput("unf_clr", 32'(unf0), 0);
      applyStimulus(0, 1, 0, 1, '0);
      checkOutput("unf_setwins", 32'(unf0), 1);
      applyStimulus(0, 0, 0, 1, '0);
      checkOutput("unf_clr2", 32'(unf1), 0);

      // Replace-top and push+pop on empty
      applyStimulus(1, 0, 0, 0, 12'hAAA);
      applyStimulus(1, 0, 0, 0, 12'hBBB);
      applyStimulus(1, 1, 0, 0, 12'hCCC);
      checkOutput("repl_count", 32'(count0), 2);
      checkOutput("repl_top",   32'(top0), 32'hCCC);
      checkOutput("repl_flags", {30'd0, ovf0, unf0}, 0);
      applyStimulus(0, 1, 0, 0, '0);
      checkOutput("repl_pop_top", 32'(top0), 32'hAAA);
      applyStimulus(0, 1, 0, 0, '0);
      applyStimulus(1, 1, 0, 0, 12'h123);
      checkOutput("pp_empty_count", 32'(count0), 1);
      checkOutput("pp_empty_top",   32'(top0), 32'h123);
      checkOutput("pp_empty_flags", {30'd0, ovf0, unf0}, 0);
      applyStimulus(0, 1, 0, 0, '0);

      // Flush beats push
      applyStimulus(1, 0, 0, 0, 12'h001);
      applyStimulus(1, 0, 0, 0, 12'h002);
      applyStimulus(1, 0, 0, 0, 12'h003);
      applyStimulus(1, 0, 1, 0, 12'h7FF);
      checkOutput("flush_count", 32'(count0), 0);
      checkOutput("flush_empty", 32'(empty0), 1);
      checkOutput("flush_top",   32'(top0), 0);
      applyStimulus(1, 0, 0, 0, 12'h055);
      checkOutput("post_flush_top", 32'(top0), 32'h055);

      // Asynchronous reset between edges
      applyStimulus(1, 0, 0, 0, 12'h066);
      checkOutput("pre_rst_count", 32'(count0), 2);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_count", 32'(count0), 0);
      checkOutput("async_rst_top",   32'(top0), 0);
      checkOutput("async_rst_empty", 32'(empty0), 1);
      checkOutput("async_rst_cnt1",  32'(count1), 0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/call_stack_unit.md
Name: call_stack_unit

Overview:
- Parametrised hardware LIFO for subroutine return addresses and saved operands; successor to the fixed push/pop stack driven by the controller.
- Adds configurable width and depth, a wrap (circular overwrite) mode, simultaneous push+pop as replace-top, flush, occupancy count and sticky overflow/underflow flags.
- Sits in the DataPath between the PC/register-file write-back mux and the PC-select mux.
- The controller drives push, pop and flush; the controller reads the flags.

Parameters:
- WIDTH, 12, bits per entry (PC width).
- DEPTH, 8, number of entries; must be >= 2.
- WRAP, 0, full-stack behaviour: 0 = reject push; 1 = overwrite oldest entry (circular).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- push  in  1  push data_in this cycle.
- pop  in  1  discard top entry this cycle.
- flush  in  1  empty the stack this cycle; highest priority.
- clear_err  in  1  clear sticky overflow/underflow.
- data_in  in  WIDTH  value to push.
- top  out  WIDTH  current top entry, combinational from state; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push hit a full stack.
- underflow  out  1  sticky: a pop hit an empty stack.

Behaviour:
- Reset (async, any time, including mid-operation):
  - count = 0, internal top pointer = 0.
  - overflow = underflow = 0.
  - top = 0, empty = 1, full = 0.
  - Storage array is not cleared; it is never visible while empty.
- Storage is a circular buffer of DEPTH entries plus a write pointer wp.
  - top = mem[(wp-1) mod DEPTH] when count > 0, otherwise 0.
  - Pointer arithmetic wraps modulo DEPTH; DEPTH need not be a power of two.
- Operation priority per cycle: flush > (push,pop) combination.
- flush=1:
  - count <- 0, wp unchanged.
  - push and pop are ignored that cycle.
  - Flags are unchanged unless clear_err is also asserted.
- push=1, pop=0:
  - Not full: mem[wp] <- data_in; wp+1; count+1.
  - Full, WRAP=0: no state change; overflow <- 1.
  - Full, WRAP=1: mem[wp] <- data_in; wp+1; count stays DEPTH; oldest entry is lost; overflow <- 1.
- push=0, pop=1:
  - Not empty: wp-1; count-1.
  - Empty: no state change; underflow <- 1.
- push=1, pop=1:
  - Not empty: replace top, i.e. mem[wp-1] <- data_in; wp and count unchanged; no flag.
  - Empty: behaves as push alone; count becomes 1; no flag.
- Latency:
  - A push is visible on top one cycle later (after the edge).
  - After a pop, top shows the next-older entry after the edge.
  - No same-cycle bypass of data_in to top.
- Sticky flags:
  - Set as above; held until clear_err or reset.
  - If clear_err and a new error event occur in the same cycle, set wins (flag = 1).
- empty and full are decoded combinationally from count only.

Test Plan (DEPTH=4, WIDTH=12 unless noted):
- Reset, then push 0x011, 0x022, 0x033 on three consecutive cycles -> count=3, top=0x033. Then pop twice -> top=0x011, count=1, no flags.
- WRAP=0: push 0x1,0x2,0x3,0x4,0x5 -> full=1, count=4, top=0x4, overflow=1. Then pop x4 -> tops read 0x4,0x3,0x2,0x1, then empty=1, top=0.
- WRAP=1: push 0x1..0x6 -> count=4, overflow=1. Pop x4 -> tops read 0x6,0x5,0x4,0x3; entries 0x1 and 0x2 are lost.
- Pop on empty -> underflow=1, count=0. clear_err alone -> underflow=0. clear_err with another empty pop in the same cycle -> underflow stays 1.
- Simultaneous push+pop:
  - With stack holding 0xAAA, 0xBBB, push+pop with data 0xCCC -> count=2, top=0xCCC. A later pop -> top=0xAAA.
  - On an empty stack, push+pop with data 0x123 -> count=1, top=0x123, no flag.
- Push 0x3 entries, then flush with push=1 in the same cycle -> count=0, empty=1, top=0. Assert reset asynchronously between clock edges while count=2 -> outputs clear immediately, without waiting for an edge.
